// File: rtl/div_pkg.sv
// Shared types and helpers for the div_gen iterative divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, INIT, CALC, FIX} div_state_t;

  // Two's-complement conditional negate on a 64-bit carrier; callers truncate to WIDTH.
  function automatic logic [63:0] cneg(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the radix-2 divider.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             qbit
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sh       = {acc, dvd[WIDTH-1]};
    diff     = sh - {2'b00, dvs};
    qbit     = ~diff[WIDTH+1];
    acc_next = qbit ? diff[WIDTH:0] : sh[WIDTH:0];
    dvd_next = {dvd[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/div_gen.sv
// Iterative radix-2 signed/unsigned divider behind a start/busy handshake.
// Define DIV_EARLY_EN to finish |x|<|y| and |x|==|y| cases in INIT.
module div_gen
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [WIDTH-1:0] xs, ys, xm, ym;
  logic             sgn_r, negq, negr, nq, nr;
  logic [WIDTH:0]   acc, acc_nx;
  logic [WIDTH-1:0] dvd, dvd_nx, dvs;
  logic             qbit;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    nr = sgn_r & xs[WIDTH-1];
    nq = sgn_r & (xs[WIDTH-1] ^ ys[WIDTH-1]);
    xm = WIDTH'(cneg(64'(xs), nr));
    ym = WIDTH'(cneg(64'(ys), sgn_r & ys[WIDTH-1]));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .dvd      (dvd),
    .dvs      (dvs),
    .acc_next (acc_nx),
    .dvd_next (dvd_nx),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      q     <= '0;
      r     <= '0;
      xs    <= '0;
      ys    <= '0;
      sgn_r <= 1'b0;
      negq  <= 1'b0;
      negr  <= 1'b0;
      acc   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            xs    <= x;
            ys    <= y;
            sgn_r <= sgn;
            busy  <= 1'b1;
            valid <= 1'b0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
            q     <= '0;
            r     <= '0;
            state <= INIT;
          end
        end
        INIT: begin
          if (ys == '0) begin
            dbz   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sgn_r && xs == MIN_VAL && ys == '1) begin
            ovf   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef DIV_EARLY_EN
          else if (xm < ym) begin
            q     <= '0;
            r     <= xs;
            valid <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (xm == ym) begin
            q     <= nq ? '1 : WIDTH'(1);
            r     <= '0;
            valid <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`endif
          else begin
            acc   <= '0;
            dvd   <= xm;
            dvs   <= ym;
            cnt   <= '0;
            negq  <= nq;
            negr  <= nr;
            state <= CALC;
          end
        end
        CALC: begin
          // Quotient bits shift into the vacated dividend LSBs.
          acc <= acc_nx;
          dvd <= dvd_nx | WIDTH'(qbit);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          q     <= WIDTH'(cneg(64'(dvd), negq));
          r     <= WIDTH'(cneg(64'(acc[WIDTH-1:0]), negr));
          valid <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_gen.sv
// Directed self-checking bench for div_gen at WIDTH=8.
module tb_div_gen;

  localparam int unsigned W = 8;
`ifdef DIV_EARLY_EN
  localparam int LAT_EARLY = 1;
`else
  localparam int LAT_EARLY = 10;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done, valid, dbz, ovf;
  logic [W-1:0] q, r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_gen #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .dbz   (dbz),
    .ovf   (ovf),
    .q     (q),
    .r     (r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic [2:0] ef,
                    input int elat);
    int lat;
    @(negedge clk);
    sgn = s; x = a; y = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_flags"}, {valid, dbz, ovf}, ef);
    check({tag, "_idle"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_strobe"}, {done, valid, dbz, ovf}, {1'b0, ef});
  endtask

  initial begin
    int lat;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset", {busy, done, valid, dbz, ovf, q, r}, 0);
    @(negedge clk) rst_n = 1'b1;

    op("u7_2",    1'b0, 8'd7,   8'd2,   8'd3,   8'd1,   3'b100, 10);
    op("sm7_2",   1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF,  3'b100, 10);
    op("s7_m2",   1'b1, 8'd7,   8'hFE,  8'hFD,  8'h01,  3'b100, 10);
    op("dbz",     1'b0, 8'd5,   8'd0,   8'd0,   8'd0,   3'b010, 1);
    op("ovf",     1'b1, 8'h80,  8'hFF,  8'd0,   8'd0,   3'b001, 1);
    op("u255_1",  1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   3'b100, 10);
    op("u8_9",    1'b0, 8'd8,   8'd9,   8'd0,   8'd8,   3'b100, LAT_EARLY);
    op("smin_1",  1'b1, 8'h80,  8'd1,   8'h80,  8'd0,   3'b100, 10);
    op("sm5_5",   1'b1, 8'hFB,  8'd5,   8'hFF,  8'd0,   3'b100, LAT_EARLY);
    op("u0_dbz",  1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   3'b010, 1);

    // Start while busy must be ignored.
    @(negedge clk);
    sgn = 1'b0; x = 8'd100; y = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    x = 8'd1; y = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_ign_busy", busy, 1);
    wait_done(lat);
    check("busy_ign_lat", lat, 6);
    check("busy_ign_q", q, 8'd14);
    check("busy_ign_r", r, 8'd2);

    // Start presented during the done cycle is accepted.
    sgn = 1'b0; x = 8'd9; y = 8'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_start_busy", {busy, valid}, 2'b10);
    wait_done(lat);
    check("done_start_lat", lat, 10);
    check("done_start_q", q, 8'd2);
    check("done_start_r", r, 8'd1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    sgn = 1'b0; x = 8'd200; y = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {busy, done, valid, dbz, ovf, q, r}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen = seen | done | busy;
    end
    check("rst_no_done", seen, 0);
    op("u9_3",    1'b0, 8'd9,   8'd3,   8'd3,   8'd0,   3'b100, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
